// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array front end.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_LOAD,
        ST_STREAM,
        ST_DRAIN
    } feeder_state_t;

    // PE multiply-add pipeline depth; the extra stage is the PE output register.
    localparam int PE_MAC_DEPTH       = 3;
    localparam int PE_LATENCY_DEFAULT = PE_MAC_DEPTH + 1;

endpackage

// File: rtl/systolic_skew_row.sv
// Fixed-depth delay line with synchronous clear; depth 0 degenerates to a wire.
module systolic_skew_row #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_line
            logic [WIDTH-1:0] line [DEPTH];

            always_ff @(posedge clk) begin
                if (clear) begin
                    for (int i = 0; i < DEPTH; i++) line[i] <= '0;
                end else begin
                    line[0] <= din;
                    for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
                end
            end

            assign dout = line[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_feeder.sv
// Weight-load and skewed activation sequencer for the top/left edges of the PE array.
//
// state   | meaning
// IDLE    | waiting; weight beat has priority over activation
// COLLECT | buffering weight rows 1..ROWS-1
// LOAD    | ROWS cycles of ld_weight, bottom row first
// STREAM  | accepting activation vectors into the skew lines
// DRAIN   | flushing the skew lines with zeros, done on last cycle
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DATA_SIZE  = 32,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int PE_LATENCY = PE_LATENCY_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      w_valid,
    output logic                      w_ready,
    input  logic [COLS*DATA_SIZE-1:0] w_data,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic                      a_last,
    input  logic [ROWS*DATA_SIZE-1:0] a_data,
    output logic                      pe_enable,
    output logic                      ld_weight,
    output logic [COLS*DATA_SIZE-1:0] col_sum,
    output logic [ROWS*DATA_SIZE-1:0] row_data,
    output logic                      busy,
    output logic                      done
);

    localparam int DRAIN_RAW = (ROWS > 1) ? (ROWS - 1) * PE_LATENCY : 1;
    localparam int DRAIN_LEN = (DRAIN_RAW > 0) ? DRAIN_RAW : 1;
    localparam int CNT_MAX   = (ROWS > DRAIN_LEN) ? ROWS : DRAIN_LEN;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(ROWS - 1);

    feeder_state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] wr_idx, idx_n;
    logic [IDX_W-1:0] rd_idx;
    logic             weights_loaded;
    logic             load_done;
    logic             a_fire;
    logic [COLS*DATA_SIZE-1:0] wbuf [ROWS];

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = wr_idx;
        load_done = 1'b0;
        w_ready   = 1'b0;
        a_ready   = 1'b0;
        case (state)
            ST_IDLE, ST_COLLECT: begin
                w_ready = 1'b1;
                if (state == ST_IDLE) a_ready = weights_loaded && !w_valid;
                if (w_valid) begin
                    if (wr_idx == IDX_LAST) begin
                        state_n = ST_LOAD;
                        cnt_n   = LOAD_LAST;
                        idx_n   = '0;
                    end else begin
                        state_n = ST_COLLECT;
                        idx_n   = wr_idx + 1'b1;
                    end
                end else if (a_valid && a_ready) begin
                    state_n = a_last ? ST_DRAIN : ST_STREAM;
                    cnt_n   = DRAIN_LAST;
                end
            end
            ST_LOAD: begin
                if (cnt == '0) begin
                    state_n   = ST_IDLE;
                    load_done = 1'b1;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_STREAM: begin
                a_ready = 1'b1;
                if (a_valid && a_last) begin
                    state_n = ST_DRAIN;
                    cnt_n   = DRAIN_LAST;
                end
            end
            ST_DRAIN: begin
                if (cnt == '0) state_n = ST_IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
        // Handshakes stay low while reset is held, whatever the state.
        if (reset) begin
            w_ready = 1'b0;
            a_ready = 1'b0;
        end
    end

    assign a_fire = a_valid && a_ready;
    assign rd_idx = cnt_n[IDX_W-1:0];

    // Registered outputs follow the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            wr_idx         <= '0;
            weights_loaded <= 1'b0;
            pe_enable      <= 1'b0;
            ld_weight      <= 1'b0;
            col_sum        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            for (int i = 0; i < ROWS; i++) wbuf[i] <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            wr_idx <= idx_n;
            if (w_ready && w_valid) wbuf[wr_idx] <= w_data;
            if (load_done) weights_loaded <= 1'b1;
            pe_enable <= (state_n == ST_LOAD) || (state_n == ST_STREAM) || (state_n == ST_DRAIN);
            ld_weight <= (state_n == ST_LOAD);
            // On LOAD entry the top slot is still being written, so take it straight from w_data.
            if (state_n == ST_LOAD) col_sum <= (state == ST_LOAD) ? wbuf[rd_idx] : w_data;
            else                    col_sum <= '0;
            busy <= (state_n != ST_IDLE);
            done <= (state_n == ST_DRAIN) && (cnt_n == '0);
        end
    end

    // Each row's line includes the output register, hence the +1.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DATA_SIZE-1:0] lane_in;
        assign lane_in = a_fire ? a_data[r*DATA_SIZE +: DATA_SIZE] : '0;
        systolic_skew_row #(
            .DEPTH(r * PE_LATENCY + 1),
            .WIDTH(DATA_SIZE)
        ) u_skew (
            .clk  (clk),
            .clear(reset),
            .din  (lane_in),
            .dout (row_data[r*DATA_SIZE +: DATA_SIZE])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench: accepted beats schedule expected edge outputs; a negedge monitor checks them.
module tb_systolic_feeder;

    localparam int DW = 32;
    localparam int R  = 2;
    localparam int C  = 2;
    localparam int L  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              w_valid = 1'b0;
    logic              w_ready;
    logic [C*DW-1:0]   w_data = '0;
    logic              a_valid = 1'b0;
    logic              a_ready;
    logic              a_last = 1'b0;
    logic [R*DW-1:0]   a_data = '0;
    logic              pe_enable, ld_weight, busy, done;
    logic [C*DW-1:0]   col_sum;
    logic [R*DW-1:0]   row_data;

    systolic_feeder #(.DATA_SIZE(DW), .ROWS(R), .COLS(C), .PE_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .a_valid(a_valid), .a_ready(a_ready), .a_last(a_last), .a_data(a_data),
        .pe_enable(pe_enable), .ld_weight(ld_weight), .col_sum(col_sum),
        .row_data(row_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [63:0]   val;
    } ev_t;

    ev_t         row_q [R][$];
    ev_t         col_q [$];
    int          done_q [$];
    logic [63:0] wbeats [R];
    int          wcount = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] rand_vec();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v;
    endfunction

    // Weight beat k is the weights of PE row k; the array is loaded bottom row first.
    function automatic void note_wbeat(input logic [63:0] w);
        ev_t e;
        wbeats[wcount] = w;
        wcount++;
        if (wcount == R) begin
            for (int i = 0; i < R; i++) begin
                e.cyc = cyc + 1 + i;
                e.val = wbeats[R-1-i];
                col_q.push_back(e);
            end
            wcount = 0;
        end
    endfunction

    // Row r shows lane r of a vector accepted in cycle n during cycle n+1+r*L.
    function automatic void note_act(input logic [63:0] v, input logic last);
        ev_t e;
        for (int r = 0; r < R; r++) begin
            e.cyc = cyc + 1 + r * L;
            e.val = 64'(v[r*DW +: DW]);
            row_q[r].push_back(e);
        end
        if (last) done_q.push_back(cyc + ((R > 1) ? (R - 1) * L : 1));
    endfunction

    always @(negedge clk) begin
        ev_t         t;
        logic [63:0] e;
        logic        exp_ld, exp_done;
        if (mon_en) begin
            for (int r = 0; r < R; r++) begin
                e = '0;
                if (row_q[r].size() > 0 && row_q[r][0].cyc == cyc) begin
                    t = row_q[r].pop_front();
                    e = t.val;
                end
                chk($sformatf("row_data[%0d]", r), 64'(row_data[r*DW +: DW]), e);
            end
            exp_ld = (col_q.size() > 0 && col_q[0].cyc == cyc);
            chk("ld_weight", 64'(ld_weight), 64'(exp_ld));
            if (exp_ld) begin
                t = col_q.pop_front();
                chk("col_sum", col_sum, t.val);
                chk("pe_enable_load", 64'(pe_enable), 64'd1);
            end else begin
                chk("col_sum_zero", col_sum, 64'd0);
            end
            exp_done = (done_q.size() > 0 && done_q[0] == cyc);
            chk("done", 64'(done), 64'(exp_done));
            if (exp_done) void'(done_q.pop_front());
        end
    end

    task automatic send_w(input logic [63:0] w);
        @(negedge clk);
        w_valid = 1'b1;
        w_data  = w;
        #1;
        chk("w_ready", 64'(w_ready), 64'd1);
        if (w_ready) note_wbeat(w);
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        w_data  = rand_vec();
    endtask

    task automatic send_act(input logic [63:0] v, input logic last);
        @(negedge clk);
        a_valid = 1'b1;
        a_data  = v;
        a_last  = last;
        #1;
        chk("a_ready", 64'(a_ready), 64'd1);
        if (a_ready) note_act(v, last);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_last  = 1'b0;
        a_data  = rand_vec();
    endtask

    task automatic bubble(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n;
        int pend;
        n = 0;
        pend = 1;
        while (pend != 0 && n < 200) begin
            @(negedge clk);
            #2;
            pend = col_q.size() + done_q.size() + (busy ? 1 : 0);
            for (int r = 0; r < R; r++) pend += row_q[r].size();
            n++;
        end
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_pending", 64'(pend), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        logic [63:0] v;
        int          len;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_w_ready", 64'(w_ready), 64'd0);
        chk("rst_a_ready", 64'(a_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pe_enable", 64'(pe_enable), 64'd0);
        chk("rst_ld_weight", 64'(ld_weight), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_col_sum", col_sum, 64'd0);
        chk("rst_row_data", row_data, 64'd0);
        reset = 1'b0;
        #1;
        chk("idle_w_ready", 64'(w_ready), 64'd1);
        chk("no_weights_a_ready", 64'(a_ready), 64'd0);
        mon_en = 1'b1;

        // Directed weight load with a bubble between beats
        send_w({32'd2, 32'd1});
        bubble(1);
        send_w({32'd4, 32'd3});
        wait_idle();
        #1;
        chk("loaded_a_ready", 64'(a_ready), 64'd1);

        // Directed skew
        send_act({32'd6, 32'd5}, 1'b0);
        send_act({32'd8, 32'd7}, 1'b1);
        wait_idle();

        // Bubble in the middle of a stream
        send_act(rand_vec() | 64'h1_0000_0001, 1'b0);
        bubble(1);
        send_act(rand_vec() | 64'h1_0000_0001, 1'b1);
        wait_idle();

        // Weight beat wins over an activation in IDLE
        @(negedge clk);
        v = rand_vec();
        w_valid = 1'b1;
        w_data  = v;
        a_valid = 1'b1;
        a_data  = rand_vec() | 64'h1_0000_0001;
        a_last  = 1'b1;
        #1;
        chk("prio_w_ready", 64'(w_ready), 64'd1);
        chk("prio_a_ready", 64'(a_ready), 64'd0);
        if (w_ready) note_wbeat(v);
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("prio_collect_busy", 64'(busy), 64'd1);
        chk("prio_collect_pe_enable", 64'(pe_enable), 64'd0);
        chk("prio_collect_a_ready", 64'(a_ready), 64'd0);
        a_valid = 1'b0;
        a_last  = 1'b0;
        send_w(rand_vec());
        wait_idle();

        // Reset during the second LOAD cycle
        send_w(rand_vec());
        send_w(rand_vec());
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rstload_ld_weight", 64'(ld_weight), 64'd0);
        chk("rstload_busy", 64'(busy), 64'd0);
        chk("rstload_pe_enable", 64'(pe_enable), 64'd0);
        chk("rstload_a_ready", 64'(a_ready), 64'd0);
        chk("rstload_w_ready", 64'(w_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("rstload_unloaded_a_ready", 64'(a_ready), 64'd0);
        chk("rstload_idle_w_ready", 64'(w_ready), 64'd1);

        // Random reloads and streams
        for (int it = 0; it < 10; it++) begin
            if (it == 0 || $urandom_range(0, 2) == 0) begin
                send_w(rand_vec());
                bubble($urandom_range(0, 2));
                send_w(rand_vec());
                wait_idle();
                #1;
                chk("rand_loaded_a_ready", 64'(a_ready), 64'd1);
            end
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                send_act(rand_vec() | 64'h1_0000_0001, (k == len - 1));
                if (k < len - 1) bubble($urandom_range(0, 2));
            end
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
